// File: rtl/vip_uart_receiver_if.sv
// UART receiver VIP bus: serial input, consumer acknowledge and the
// registered byte/flag outputs of the one-deep holding register.
interface vip_uart_receiver_if;
  logic       i_rx;
  logic       i_rdy_clr;
  logic       o_rdy;
  logic [7:0] o_rdata;
  logic       o_overflow;
  logic       o_frame_err;

  // Receiver side
  modport slave (
    input  i_rx,
    input  i_rdy_clr,
    output o_rdy,
    output o_rdata,
    output o_overflow,
    output o_frame_err
  );

  // Line driver / byte consumer side
  modport master (
    output i_rx,
    output i_rdy_clr,
    input  o_rdy,
    input  o_rdata,
    input  o_overflow,
    input  o_frame_err
  );
endinterface

// File: rtl/vip_uart_receiver.sv
// UART 8N1 receive VIP. Oversamples the line with a half-bit counter,
// samples every bit at its midpoint and hands complete bytes to a one-deep
// holding register with ready/clear handshake, overflow and framing flags.
module vip_uart_receiver #(
  parameter int scaler = 8          // half bit period in clocks, >= 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  vip_uart_receiver_if.slave    bus
);

  localparam int P  = 2 * scaler;
  localparam int CW = (P > 2) ? $clog2(P) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(scaler - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(P - 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitpos_q, bitpos_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_ff1_q, rx_ff2_q;
  logic          rdy_q, rdy_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;
  logic          commit;
  logic          ferr_set;

  // Synchronizer for the asynchronous line; idles high so reset looks idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_ff1_q <= 1'b1;
      rx_ff2_q <= 1'b1;
    end else begin
      rx_ff1_q <= bus.i_rx;
      rx_ff2_q <= rx_ff1_q;
    end
  end

  // Frame FSM, sample counter, shifter and holding register state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_WAIT_HIGH;
      cnt_q    <= '0;
      bitpos_q <= '0;
      shift_q  <= 8'h00;
      rdy_q    <= 1'b0;
      rdata_q  <= 8'h00;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitpos_q <= bitpos_d;
      shift_q  <= shift_d;
      rdy_q    <= rdy_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
    end
  end

  // Next-state: frame sequencing with mid-bit sampling, then flag/commit update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    bitpos_d = bitpos_q;
    shift_d  = shift_q;
    rdy_d    = rdy_q;
    rdata_d  = rdata_q;
    ovf_d    = ovf_q;
    ferr_d   = ferr_q;
    commit   = 1'b0;
    ferr_set = 1'b0;

    case (state_q)
      // After reset or a framing error the line must go idle before a
      // falling edge is trusted as a start bit.
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_ff2_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_ff2_q) state_d = S_START;
      end
      // Recheck the line half a bit in; a high here was only a glitch.
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_ff2_q) begin
            state_d  = S_DATA;
            bitpos_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      // From the start midpoint every full period lands mid-bit; LSB first.
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          shift_d  = {rx_ff2_q, shift_q[7:1]};
          bitpos_d = bitpos_q + 3'd1;
          if (bitpos_q == 3'd7) state_d = S_STOP;
        end
      end
      // Re-arm at the stop midpoint so a directly following start is seen.
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_ff2_q) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_WAIT_HIGH;
      end
    endcase

    // Acknowledge clears everything first; a same-cycle commit or framing
    // error then takes precedence over the clear.
    if (bus.i_rdy_clr) begin
      rdy_d  = 1'b0;
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (commit) begin
      if (!rdy_q || bus.i_rdy_clr) begin
        rdata_d = shift_q;
        rdy_d   = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (ferr_set) ferr_d = 1'b1;
  end

  assign bus.o_rdy       = rdy_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_frame_err = ferr_q;

endmodule

// File: tb/tb_vip_uart_receiver.sv
// Directed bench for the UART receive VIP: latency, back-to-back frames,
// overflow, framing error, glitch rejection, mid-frame reset and a commit
// coincident with acknowledge.
module tb_vip_uart_receiver;
  localparam int SCALER = 8;
  localparam int P      = 2 * SCALER;
  localparam int LAT    = 2 + SCALER + 9 * P;   // E0 to stop-sample edge

  logic i_clk = 1'b0;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;
  logic ok;

  vip_uart_receiver_if u_if ();

  vip_uart_receiver #(.scaler(SCALER)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (u_if)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a negedge; stop level/length selectable.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    u_if.i_rx = 1'b0;
    repeat (P) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      u_if.i_rx = b[i];
      repeat (P) @(negedge i_clk);
    end
    u_if.i_rx = stop;
    repeat (stop_len) @(negedge i_clk);
    u_if.i_rx = 1'b1;
  endtask

  task automatic wait_rdy(output logic got);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge i_clk);
      got = u_if.o_rdy;
    end
  endtask

  task automatic pulse_clr();
    u_if.i_rdy_clr = 1'b1;
    @(negedge i_clk);
    u_if.i_rdy_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    u_if.i_rx = 1'b1;
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    i_rst          = 1'b1;
    u_if.i_rx      = 1'b1;
    u_if.i_rdy_clr = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_rdy",   u_if.o_rdy,       0);
    chk("rst_rdata", u_if.o_rdata,     8'h00);
    chk("rst_ovf",   u_if.o_overflow,  0);
    chk("rst_ferr",  u_if.o_frame_err, 0);
    i_rst = 1'b0;
    idle(4);

    // Latency of a single frame, then data and acknowledge
    fork
      send_frame(8'hA5, 1'b1, P);
      begin
        repeat (LAT) @(negedge i_clk);
        chk("lat_before", u_if.o_rdy, 0);
        @(negedge i_clk);
        chk("lat_at", u_if.o_rdy, 1);
      end
    join
    chk("a5_rdata", u_if.o_rdata,     8'hA5);
    chk("a5_ovf",   u_if.o_overflow,  0);
    chk("a5_ferr",  u_if.o_frame_err, 0);
    pulse_clr();
    chk("a5_clr_rdy", u_if.o_rdy, 0);
    idle(P);

    // Back-to-back frames read promptly
    fork
      begin
        send_frame(8'h00, 1'b1, P);
        send_frame(8'hFF, 1'b1, P);
        send_frame(8'h55, 1'b1, P);
      end
      begin
        wait_rdy(ok); chk("b2b0_to", ok, 1); chk("b2b0_rdata", u_if.o_rdata, 8'h00); pulse_clr();
        wait_rdy(ok); chk("b2b1_to", ok, 1); chk("b2b1_rdata", u_if.o_rdata, 8'hFF); pulse_clr();
        wait_rdy(ok); chk("b2b2_to", ok, 1); chk("b2b2_rdata", u_if.o_rdata, 8'h55);
        chk("b2b_ovf",  u_if.o_overflow,  0);
        chk("b2b_ferr", u_if.o_frame_err, 0);
        pulse_clr();
      end
    join
    idle(P);

    // Overflow: second byte dropped while first is unread
    send_frame(8'h12, 1'b1, P);
    chk("ovf1_ovf", u_if.o_overflow, 0);
    send_frame(8'h34, 1'b1, P);
    chk("ovf_rdy",   u_if.o_rdy,      1);
    chk("ovf_rdata", u_if.o_rdata,    8'h12);
    chk("ovf_ovf",   u_if.o_overflow, 1);
    pulse_clr();
    chk("ovf_clr_rdy", u_if.o_rdy,      0);
    chk("ovf_clr_ovf", u_if.o_overflow, 0);
    idle(P);

    // Framing error, recovery, sticky flag until acknowledge
    send_frame(8'h3C, 1'b0, 2 * P);
    chk("fe_ferr", u_if.o_frame_err, 1);
    chk("fe_rdy",  u_if.o_rdy,       0);
    idle(2 * P);
    send_frame(8'h7E, 1'b1, P);
    chk("fe_7e_rdata", u_if.o_rdata,     8'h7E);
    chk("fe_7e_rdy",   u_if.o_rdy,       1);
    chk("fe_7e_ferr",  u_if.o_frame_err, 1);
    pulse_clr();
    chk("fe_clr_ferr", u_if.o_frame_err, 0);
    chk("fe_clr_rdy",  u_if.o_rdy,       0);
    idle(P);

    // Glitch rejection, then a normal frame proves receiver is idle again
    u_if.i_rx = 1'b0;
    repeat (3) @(negedge i_clk);
    idle(3 * P);
    chk("gl_rdy",  u_if.o_rdy,       0);
    chk("gl_ovf",  u_if.o_overflow,  0);
    chk("gl_ferr", u_if.o_frame_err, 0);
    send_frame(8'h5A, 1'b1, P);
    chk("gl_5a_rdata", u_if.o_rdata, 8'h5A);
    chk("gl_5a_rdy",   u_if.o_rdy,   1);
    idle(P);

    // Reset at bitpos 4 with an unread byte held
    u_if.i_rx = 1'b0;
    repeat (P) @(negedge i_clk);
    for (int i = 0; i < 4; i++) begin
      u_if.i_rx = (i < 2) ? 1'b1 : 1'b0;   // 8'hC3 bits 0..3
      repeat (P) @(negedge i_clk);
    end
    u_if.i_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("mr_rdy",   u_if.o_rdy,       0);
    chk("mr_rdata", u_if.o_rdata,     8'h00);
    chk("mr_ovf",   u_if.o_overflow,  0);
    chk("mr_ferr",  u_if.o_frame_err, 0);
    i_rst = 1'b0;
    idle(2 * P);
    send_frame(8'hC3, 1'b1, P);
    chk("mr_c3_rdata", u_if.o_rdata, 8'hC3);
    chk("mr_c3_rdy",   u_if.o_rdy,   1);
    idle(P);

    // Commit in the same cycle as acknowledge while a byte is held
    fork
      send_frame(8'h96, 1'b1, P);
      begin
        repeat (LAT) @(negedge i_clk);
        pulse_clr();
      end
    join
    chk("co_rdy",   u_if.o_rdy,      1);
    chk("co_rdata", u_if.o_rdata,    8'h96);
    chk("co_ovf",   u_if.o_overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
